// File: rtl/acc_ctrl.sv
// acc_ctrl -- sequencing controller for a hit-counting accumulator pass.
//
// A pass clears the external accumulator, then runs len_i lookup batches.
// Each batch issues one request to the lookup unit, waits for its hit
// vector, and lets the accumulator add it on the same edge. After the last
// batch the accumulator value is latched into result_o and done_o pulses.
// A lookup that never returns within TMO wait cycles abandons the pass and
// raises the sticky err_o. abort_i abandons any active pass silently.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      begin a pass (honoured in IDLE only)
//   len_i        number of lookup batches, sampled with start_i
//   abort_i      abandon the active pass
//   lu_req_o     lookup request, held until lu_ack_i
//   lu_ack_i     lookup unit accepted the request
//   hit_valid_i  lookup result valid this cycle
//   acc_en_o     accumulator add enable (follows hit_valid_i in WAIT)
//   acc_clear_o  accumulator synchronous clear
//   candidate_i  accumulator's registered count
//   busy_o       pass in progress
//   done_o       one-cycle completion pulse
//   result_o     count latched at pass completion
//   err_o        sticky lookup-timeout flag
module acc_ctrl #(
  parameter int LU_W   = 4,
  parameter int CAND_W = 8,
  parameter int LEN_W  = 8,
  parameter int TMO    = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              abort_i,
  output logic              lu_req_o,
  input  logic              lu_ack_i,
  input  logic              hit_valid_i,
  output logic              acc_en_o,
  output logic              acc_clear_o,
  input  logic [CAND_W-1:0] candidate_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CAND_W-1:0] result_o,
  output logic              err_o
);

  // The wait counter only ever needs to reach TMO-1: the cycle in which it
  // holds TMO-1 without a hit is the TMO-th waiting cycle, i.e. the timeout.
  localparam int WAIT_W = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [WAIT_W-1:0] TMO_M1 = WAIT_W'(TMO - 1);

  if (LU_W < 1 || CAND_W < 1 || LEN_W < 1 || TMO < 1) begin : g_param_check
    $error("acc_ctrl: LU_W, CAND_W, LEN_W and TMO must all be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CAND_W-1:0]  result_q, result_d;
  logic               err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      wait_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      wait_q   <= wait_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    wait_d      = wait_q;
    result_d    = result_q;
    err_d       = err_q;
    lu_req_o    = 1'b0;
    acc_en_o    = 1'b0;
    acc_clear_o = 1'b0;
    done_o      = 1'b0;

    // Abort outranks every other event of the cycle: no add, no handshake,
    // no timeout flag, no result update, and all strobes stay low.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            rem_d = len_i;
            err_d = 1'b0;
            if (len_i == '0) begin
              // Empty pass: nothing to count, report zero straight away.
              result_d = '0;
              state_d  = S_DONE;
            end else begin
              state_d = S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          acc_clear_o = 1'b1;
          state_d     = S_ISSUE;
        end
        S_ISSUE: begin
          lu_req_o = 1'b1;
          if (lu_ack_i) begin
            wait_d  = '0;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (hit_valid_i) begin
            // Accumulator adds on this same edge.
            acc_en_o = 1'b1;
            rem_d    = rem_q - 1'b1;
            state_d  = (rem_q == LEN_W'(1)) ? S_DRAIN : S_ISSUE;
          end else if (wait_q == TMO_M1) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        S_DRAIN: begin
          // candidate_i now includes the last add.
          result_d = candidate_i;
          state_d  = S_DONE;
        end
        S_DONE: begin
          done_o  = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign result_o = result_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_acc_ctrl.sv
module tb_acc_ctrl;

  localparam int LU_W   = 4;
  localparam int CAND_W = 8;
  localparam int LEN_W  = 8;
  localparam int TMO_P  = 5;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              start_i;
  logic [LEN_W-1:0]  len_i;
  logic              abort_i;
  logic              lu_req_o;
  logic              lu_ack_i;
  logic              hit_valid_i;
  logic              acc_en_o;
  logic              acc_clear_o;
  logic [CAND_W-1:0] candidate_i;
  logic              busy_o;
  logic              done_o;
  logic [CAND_W-1:0] result_o;
  logic              err_o;

  logic [LU_W-1:0]   hit_vec_i;
  logic [CAND_W-1:0] acc_q;

  int tests = 0;
  int fails = 0;
  int exp_result = 0;
  bit use_dvec = 0;
  logic [LU_W-1:0] dvec [16];

  always #5 clk_i = ~clk_i;

  acc_ctrl #(
    .LU_W  (LU_W),
    .CAND_W(CAND_W),
    .LEN_W (LEN_W),
    .TMO   (TMO_P)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .len_i      (len_i),
    .abort_i    (abort_i),
    .lu_req_o   (lu_req_o),
    .lu_ack_i   (lu_ack_i),
    .hit_valid_i(hit_valid_i),
    .acc_en_o   (acc_en_o),
    .acc_clear_o(acc_clear_o),
    .candidate_i(candidate_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .err_o      (err_o)
  );

  // Stand-in accumulator: adds the number of set bits of the hit vector.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          acc_q <= '0;
    else if (acc_clear_o) acc_q <= '0;
    else if (acc_en_o)    acc_q <= acc_q + CAND_W'($countones(hit_vec_i));
  end
  assign candidate_i = acc_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests = tests + 1;
    assert (obs === exp_v) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One pass. Called and returning at posedge+1 with the DUT idle.
  // ack_fix/hit_fix < 0 pick random delays; tmo_b/abort_b/rst_b >= 0 select
  // the batch on which the lookup never answers / abort fires with the hit /
  // reset is pulled in the first WAIT cycle.
  task automatic run_pass(input int len, input int ack_fix, input int hit_fix,
                          input int tmo_b, input int abort_b, input int rst_b);
    int a [16];
    int h [16];
    logic [LU_W-1:0] v [16];
    int sum, req_exp, lat_exp, b, iw, hw;
    int n_clr, n_en, n_hs, n_req, n_done, done_cyc, post_busy, post_done;
    bit pend, ended, hs_now, req_now, abort_now, hit_now;
    sum = 0; req_exp = 0; lat_exp = 0; b = 0; iw = 0; hw = 0;
    n_clr = 0; n_en = 0; n_hs = 0; n_req = 0; n_done = 0; done_cyc = -1;
    post_busy = 0; post_done = 0;
    pend = 0; ended = 0;
    for (int i = 0; i < len; i++) begin
      a[i] = (ack_fix >= 0) ? ack_fix : $urandom_range(0, 3);
      h[i] = (hit_fix >= 0) ? hit_fix : $urandom_range(0, 3);
      if (i == tmo_b) h[i] = 1000;
      v[i] = use_dvec ? dvec[i] : LU_W'($urandom);
      sum     += $countones(v[i]);
      req_exp += a[i] + 1;
      lat_exp += a[i] + 1 + h[i] + 1;
    end
    lat_exp = (len == 0) ? 1 : lat_exp + 3;

    start_i = 1'b1; len_i = LEN_W'(len);
    abort_i = 1'b0; lu_ack_i = 1'b0; hit_valid_i = 1'b0;
    @(negedge clk_i);
    chk("idle_before_start", busy_o, 1'b0);
    @(posedge clk_i); #1;

    for (int c = 1; c < 400; c++) begin
      if (!busy_o) begin
        ended = 1;
        break;
      end
      start_i = ($urandom_range(0, 3) == 0);
      len_i = LEN_W'($urandom);
      abort_i = 1'b0; lu_ack_i = 1'b0; hit_valid_i = 1'b0;
      hit_vec_i = LU_W'($urandom);
      if (pend) begin
        if (b == rst_b && hw == 0) begin
          rst_ni = 1'b0;
          start_i = 1'b0;
          #1;
          chk("rst_lu_req", lu_req_o, 1'b0);
          chk("rst_acc_en", acc_en_o, 1'b0);
          chk("rst_acc_clear", acc_clear_o, 1'b0);
          chk("rst_done", done_o, 1'b0);
          chk("rst_busy", busy_o, 1'b0);
          chk("rst_err", err_o, 1'b0);
          chk("rst_result", result_o, 0);
          repeat (2) @(posedge clk_i);
          @(negedge clk_i);
          rst_ni = 1'b1;
          for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            if (busy_o) post_busy++;
            if (done_o) post_done++;
          end
          chk("rst_no_busy_after", post_busy, 0);
          chk("rst_no_done_after", post_done, 0);
          exp_result = 0;
          @(posedge clk_i); #1;
          return;
        end
        if (hw == h[b]) begin
          hit_valid_i = 1'b1;
          hit_vec_i = v[b];
          if (b == abort_b) abort_i = 1'b1;
        end
      end else begin
        // Junk hit strobes outside WAIT must be ignored.
        hit_valid_i = $urandom_range(0, 1);
        if (lu_req_o) lu_ack_i = (iw == a[b]);
      end
      @(negedge clk_i);
      req_now = lu_req_o;
      hs_now = lu_req_o && lu_ack_i;
      abort_now = abort_i;
      hit_now = hit_valid_i;
      if (acc_clear_o) n_clr++;
      if (acc_en_o) n_en++;
      if (req_now) n_req++;
      if (hs_now) n_hs++;
      if (done_o) begin n_done++; done_cyc = c; end
      if (abort_now) chk("abort_acc_en", acc_en_o, 1'b0);
      if (pend) begin
        if (hit_now) begin pend = 0; b++; end
        else hw++;
      end else if (hs_now) begin
        pend = 1; hw = 0; iw = 0;
      end else if (req_now) begin
        iw++;
      end
      @(posedge clk_i); #1;
    end
    start_i = 1'b0; abort_i = 1'b0; lu_ack_i = 1'b0; hit_valid_i = 1'b0;

    chk("pass_ended", ended, 1'b1);
    if (abort_b >= 0 && abort_b < len) begin
      chk("abort_no_done", n_done, 0);
      chk("abort_result_kept", result_o, exp_result);
      chk("abort_no_err", err_o, 1'b0);
      chk("abort_adds", n_en, abort_b);
      chk("abort_handshakes", n_hs, abort_b + 1);
    end else if (tmo_b >= 0 && tmo_b < len) begin
      chk("tmo_wait_cycles", hw, TMO_P);
      chk("tmo_err", err_o, 1'b1);
      chk("tmo_no_done", n_done, 0);
      chk("tmo_result_kept", result_o, exp_result);
      chk("tmo_handshakes", n_hs, tmo_b + 1);
      chk("tmo_adds", n_en, tmo_b);
    end else begin
      chk("clear_pulses", n_clr, (len != 0) ? 1 : 0);
      chk("add_pulses", n_en, len);
      chk("handshakes", n_hs, len);
      chk("req_cycles", n_req, req_exp);
      chk("done_pulses", n_done, 1);
      chk("done_latency", done_cyc, lat_exp);
      chk("result", result_o, CAND_W'(sum));
      chk("err_clear", err_o, 1'b0);
      exp_result = CAND_W'(sum);
    end
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; len_i = '0; abort_i = 1'b0;
    lu_ack_i = 1'b0; hit_valid_i = 1'b0; hit_vec_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_done", done_o, 1'b0);
    chk("reset_err", err_o, 1'b0);
    chk("reset_result", result_o, 0);
    chk("reset_lu_req", lu_req_o, 1'b0);
    chk("reset_acc_clear", acc_clear_o, 1'b0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Three batches, hits of 4, 2 and 1 bits: result 7.
    dvec[0] = 4'b1111; dvec[1] = 4'b0011; dvec[2] = 4'b0100;
    use_dvec = 1;
    run_pass(3, 1, 1, -1, -1, -1);
    use_dvec = 0;
    chk("directed_result_7", result_o, 7);

    // Empty pass.
    run_pass(0, -1, -1, -1, -1, -1);
    chk("empty_result_0", result_o, 0);

    // Lookup unit stalls 10 cycles on every request.
    run_pass(2, 10, 0, -1, -1, -1);

    // Lookup never answers on the second batch.
    run_pass(3, -1, -1, 1, -1, -1);

    // Abort together with the second hit of a four-batch pass, then rerun.
    run_pass(4, -1, -1, -1, 1, -1);
    run_pass(4, -1, -1, -1, -1, -1);

    for (int r = 0; r < 20; r++)
      run_pass($urandom_range(0, 6), -1, -1, -1, -1, -1);

    // Reset during WAIT, then a zero-wait pass.
    run_pass(3, -1, -1, -1, -1, 1);
    run_pass(2, 0, 0, -1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
